// File: rtl/luna_isa_pkg.sv
// Shared ISA definitions for the Luna control path: FSM states, instruction
// field positions and the ALU control bundle decoded from a C-instruction.
package luna_isa_pkg;

    localparam int INSTR_W = 16;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        EXECUTE = 2'd1,
        HALT    = 2'd2
    } state_t;

    localparam int BIT_CI  = 15;
    localparam int BIT_A   = 12;
    localparam int BIT_ZX  = 11;
    localparam int BIT_NX  = 10;
    localparam int BIT_ZY  = 9;
    localparam int BIT_NY  = 8;
    localparam int BIT_F   = 7;
    localparam int BIT_NO  = 6;
    localparam int BIT_DA  = 5;
    localparam int BIT_DD  = 4;
    localparam int BIT_DM  = 3;
    localparam int BIT_JLT = 2;
    localparam int BIT_JEQ = 1;
    localparam int BIT_JGT = 0;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    function automatic alu_ctrl_t decode_alu_ctrl(input logic [INSTR_W-1:0] instr);
        alu_ctrl_t c;
        c.zx = instr[BIT_ZX];
        c.nx = instr[BIT_NX];
        c.zy = instr[BIT_ZY];
        c.ny = instr[BIT_NY];
        c.f  = instr[BIT_F];
        c.no = instr[BIT_NO];
        return c;
    endfunction

endpackage

// File: rtl/luna_alu.sv
// Hack-style ALU: zero/negate each operand, add or AND, optionally negate
// the result; reports zero and negative flags of the final output.
module luna_alu
    import luna_isa_pkg::*;
(
    input  logic [INSTR_W-1:0] x,
    input  logic [INSTR_W-1:0] y,
    input  logic               zx,
    input  logic               nx,
    input  logic               zy,
    input  logic               ny,
    input  logic               f,
    input  logic               no,
    output logic [INSTR_W-1:0] out,
    output logic               zr,
    output logic               ng
);

    logic [INSTR_W-1:0] x1;
    logic [INSTR_W-1:0] x2;
    logic [INSTR_W-1:0] y1;
    logic [INSTR_W-1:0] y2;
    logic [INSTR_W-1:0] r;

    always_comb begin
        x1  = zx ? '0 : x;
        x2  = nx ? ~x1 : x1;
        y1  = zy ? '0 : y;
        y2  = ny ? ~y1 : y1;
        r   = f ? (x2 + y2) : (x2 & y2);
        out = no ? ~r : r;
        zr  = (out == '0);
        ng  = out[INSTR_W-1];
    end

endmodule

// File: rtl/luna_cpu_control.sv
// Two-cycle fetch/execute controller: reads an instruction from a synchronous
// ROM, drives the A/D/M write port and advances or redirects the PC.
//
// state   | meaning
// --------+-------------------------------------------------------------
// FETCH   | rom_addr=pc presented, no writes; halt_req diverts to HALT
// EXECUTE | rom_data holds instruction; write enables live, pc updates
// HALT    | halted=1, pc frozen until halt_req drops
module luna_cpu_control
    import luna_isa_pkg::*;
#(
    parameter int PC_W    = 15,
    parameter int MADDR_W = 13
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_W-1:0]     rom_addr,
    input  logic [INSTR_W-1:0]  rom_data,
    output logic [MADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0]  reg_a_in,
    input  logic [INSTR_W-1:0]  reg_d_in,
    input  logic [INSTR_W-1:0]  reg_m_in,
    output logic [INSTR_W-1:0]  data_out,
    output logic                reg_a_en,
    output logic                reg_d_en,
    output logic                reg_m_en,
    input  logic                halt_req,
    output logic                halted,
    output logic [31:0]         retired
);

    state_t             state;
    state_t             state_next;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_next;

    logic               is_c;
    alu_ctrl_t          alu_ctrl;
    logic [INSTR_W-1:0] alu_y;
    logic [INSTR_W-1:0] alu_out;
    logic               alu_zr;
    logic               alu_ng;
    logic               jump_taken;
    logic [INSTR_W-1:0] decoded_data;

    always_comb begin
        is_c     = rom_data[BIT_CI];
        alu_ctrl = decode_alu_ctrl(rom_data);
        alu_y    = rom_data[BIT_A] ? reg_m_in : reg_a_in;
    end

    luna_alu u_alu (
        .x   (reg_d_in),
        .y   (alu_y),
        .zx  (alu_ctrl.zx),
        .nx  (alu_ctrl.nx),
        .zy  (alu_ctrl.zy),
        .ny  (alu_ctrl.ny),
        .f   (alu_ctrl.f),
        .no  (alu_ctrl.no),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    // Jump target is the A value seen during EXECUTE, before any A write lands.
    always_comb begin
        jump_taken = is_c &&
                     ((rom_data[BIT_JLT] && alu_ng) ||
                      (rom_data[BIT_JEQ] && alu_zr) ||
                      (rom_data[BIT_JGT] && !alu_ng && !alu_zr));
        pc_next    = jump_taken ? reg_a_in[PC_W-1:0] : pc + PC_W'(1);
        decoded_data = is_c ? alu_out : {1'b0, rom_data[INSTR_W-2:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= '0;
            retired <= '0;
        end else if (state == EXECUTE) begin
            pc      <= pc_next;
            retired <= retired + 32'd1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:   state_next = halt_req ? HALT : EXECUTE;
            EXECUTE: state_next = FETCH;
            HALT:    state_next = halt_req ? HALT : FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        reg_a_en = 1'b0;
        reg_d_en = 1'b0;
        reg_m_en = 1'b0;
        halted   = (state == HALT);
        data_out = rst ? '0 : decoded_data;
        if (state == EXECUTE && !rst) begin
            reg_a_en = is_c ? rom_data[BIT_DA] : 1'b1;
            reg_d_en = is_c && rom_data[BIT_DD];
            reg_m_en = is_c && rom_data[BIT_DM];
        end
    end

    assign rom_addr = pc;
    assign mem_addr = reg_a_in[MADDR_W-1:0];

endmodule

// File: tb/tb_luna_cpu_control.sv
// Bench for luna_cpu_control: emulates the instruction ROM and A/D/M block,
// runs directed vectors, random instructions against a reference model and
// halt/reset/wrap sequences.
module tb_luna_cpu_control;
    import luna_isa_pkg::*;

    localparam int PC_W    = 15;
    localparam int MADDR_W = 13;

    logic               clk = 1'b0;
    logic               rst;
    logic [PC_W-1:0]    rom_addr;
    logic [15:0]        rom_data;
    logic [MADDR_W-1:0] mem_addr;
    logic [15:0]        reg_a_in;
    logic [15:0]        reg_d_in;
    logic [15:0]        reg_m_in;
    logic [15:0]        data_out;
    logic               reg_a_en;
    logic               reg_d_en;
    logic               reg_m_en;
    logic               halt_req;
    logic               halted;
    logic [31:0]        retired;

    logic [15:0] rom [0:32767];
    logic [15:0] mem [0:8191];
    logic [15:0] env_a;
    logic [15:0] env_d;

    int          checks = 0;
    int          failures = 0;
    int          model_pc;
    int unsigned model_ret;

    always #5 clk = ~clk;

    assign reg_a_in = env_a;
    assign reg_d_in = env_d;
    assign reg_m_in = mem[mem_addr];

    luna_cpu_control #(.PC_W(PC_W), .MADDR_W(MADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .mem_addr (mem_addr),
        .reg_a_in (reg_a_in),
        .reg_d_in (reg_d_in),
        .reg_m_in (reg_m_in),
        .data_out (data_out),
        .reg_a_en (reg_a_en),
        .reg_d_en (reg_d_en),
        .reg_m_en (reg_m_en),
        .halt_req (halt_req),
        .halted   (halted),
        .retired  (retired)
    );

    typedef struct {
        logic [15:0] instr;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] m;
        logic [15:0] exp_data;
        logic [2:0]  exp_en;
        logic        exp_jump;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: sample DUT, then let the ROM and register block react.
    task automatic cycle();
        logic [PC_W-1:0]    ra;
        logic [MADDR_W-1:0] ma;
        logic [15:0]        dv;
        logic               ae, de, me;
        ra = rom_addr; ma = mem_addr; dv = data_out;
        ae = reg_a_en; de = reg_d_en; me = reg_m_en;
        @(posedge clk);
        #1;
        rom_data = rom[ra];
        if (me) mem[ma] = dv;
        if (ae) env_a = dv;
        if (de) env_d = dv;
        @(negedge clk);
    endtask

    function automatic void ref_exec(input logic [15:0] instr, input logic [15:0] a,
                                     input logic [15:0] d, input logic [15:0] m, input int pc,
                                     output logic [15:0] dv, output logic [2:0] en, output int npc);
        logic [15:0] x, y, r;
        int          sv;
        bit          jump;
        if (!instr[15]) begin
            dv  = instr;
            en  = 3'b100;
            npc = (pc + 1) % 32768;
        end else begin
            x = d;
            y = instr[12] ? m : a;
            if (instr[11]) x = 16'h0000;
            if (instr[10]) x = ~x;
            if (instr[9])  y = 16'h0000;
            if (instr[8])  y = ~y;
            r = instr[7] ? 16'(x + y) : (x & y);
            if (instr[6]) r = ~r;
            dv   = r;
            en   = instr[5:3];
            sv   = int'($signed(r));
            jump = (instr[2] && sv < 0) || (instr[1] && sv == 0) || (instr[0] && sv > 0);
            npc  = jump ? int'(a[14:0]) : (pc + 1) % 32768;
        end
    endfunction

    // Runs one instruction from FETCH to the following FETCH; starts and ends at a negedge.
    task automatic run_vec(input logic [15:0] instr, input logic [15:0] a, input logic [15:0] d,
                           input logic [15:0] m, input logic [15:0] exp_data,
                           input logic [2:0] exp_en, input int exp_npc);
        env_a = a;
        env_d = d;
        mem[a[12:0]] = m;
        rom[model_pc] = instr;
        #1;
        check("fetch_rom_addr", 32'(rom_addr), 32'(model_pc));
        check("fetch_enables", {29'd0, reg_a_en, reg_d_en, reg_m_en}, 32'd0);
        cycle();
        check("exec_data_out", 32'(data_out), 32'(exp_data));
        check("exec_enables", {29'd0, reg_a_en, reg_d_en, reg_m_en}, {29'd0, exp_en});
        check("exec_mem_addr", 32'(mem_addr), 32'(a[12:0]));
        cycle();
        model_pc = exp_npc;
        model_ret++;
        check("next_pc", 32'(rom_addr), 32'(model_pc));
        check("retired", retired, model_ret);
        if (exp_en[0]) check("m_write_old_addr", 32'(mem[a[12:0]]), 32'(exp_data));
        if (exp_en[2]) check("a_written", 32'(env_a), 32'(exp_data));
        if (exp_en[1]) check("d_written", 32'(env_d), 32'(exp_data));
    endtask

    vec_t vecs[$];

    initial begin
        logic [15:0] dv;
        logic [2:0]  en;
        int          npc;
        logic [15:0] ri, ra, rd, rm;

        vecs.push_back('{16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 3'b100, 1'b0});
        vecs.push_back('{16'hE090, 16'h0007, 16'h0005, 16'h0000, 16'h000C, 3'b010, 1'b0});
        vecs.push_back('{16'hE302, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b1});
        vecs.push_back('{16'hE302, 16'h0010, 16'h0003, 16'h0000, 16'h0003, 3'b000, 1'b0});
        vecs.push_back('{16'hFDE8, 16'h0005, 16'h0000, 16'h0009, 16'h000A, 3'b101, 1'b0});
        vecs.push_back('{16'hEC10, 16'h4321, 16'h0001, 16'h0000, 16'h4321, 3'b010, 1'b0});
        vecs.push_back('{16'hEA87, 16'h0100, 16'h0007, 16'h0000, 16'h0000, 3'b000, 1'b1});
        vecs.push_back('{16'hFC20, 16'h0040, 16'h0000, 16'hBEEF, 16'hBEEF, 3'b100, 1'b0});
        vecs.push_back('{16'hE304, 16'h0200, 16'h8000, 16'h0000, 16'h8000, 3'b000, 1'b1});
        vecs.push_back('{16'hE301, 16'h0030, 16'h0001, 16'h0000, 16'h0001, 3'b000, 1'b1});
        vecs.push_back('{16'h8090, 16'h0003, 16'h0004, 16'h0000, 16'h0007, 3'b010, 1'b0});
        vecs.push_back('{16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 3'b100, 1'b0});

        for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;
        for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
        env_a = 16'h0000;
        env_d = 16'h0000;
        rom_data = 16'h0000;
        halt_req = 1'b0;
        rst = 1'b1;

        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_enables", {29'd0, reg_a_en, reg_d_en, reg_m_en}, 32'd0);
            cycle();
        end
        rst = 1'b0;
        #1;
        check("reset_rom_addr", 32'(rom_addr), 32'd0);
        check("reset_retired", retired, 32'd0);
        check("reset_halted", {31'd0, halted}, 32'd0);
        model_pc = 0;
        model_ret = 0;

        foreach (vecs[i]) begin
            npc = vecs[i].exp_jump ? int'(vecs[i].a[14:0]) : (model_pc + 1) % 32768;
            run_vec(vecs[i].instr, vecs[i].a, vecs[i].d, vecs[i].m,
                    vecs[i].exp_data, vecs[i].exp_en, npc);
        end

        for (int i = 0; i < 150; i++) begin
            ri = 16'($urandom);
            ra = 16'($urandom);
            rd = 16'($urandom);
            rm = 16'($urandom);
            if (i % 8 == 0) rd = 16'h0000;
            ref_exec(ri, ra, rd, rm, model_pc, dv, en, npc);
            run_vec(ri, ra, rd, rm, dv, en, npc);
        end

        // Halt requested during EXECUTE: instruction completes, then HALT.
        rom[model_pc] = 16'h0042;
        cycle();
        halt_req = 1'b1;
        #1;
        check("halt_exec_a_en", {31'd0, reg_a_en}, 32'd1);
        cycle();
        model_pc = (model_pc + 1) % 32768;
        model_ret++;
        check("halt_fetch_halted", {31'd0, halted}, 32'd0);
        check("halt_fetch_pc", 32'(rom_addr), 32'(model_pc));
        cycle();
        for (int i = 0; i < 3; i++) begin
            check("halted_flag", {31'd0, halted}, 32'd1);
            check("halted_enables", {29'd0, reg_a_en, reg_d_en, reg_m_en}, 32'd0);
            check("halted_pc_held", 32'(rom_addr), 32'(model_pc));
            check("halted_retired", retired, model_ret);
            cycle();
        end
        halt_req = 1'b0;
        cycle();
        check("resume_halted", {31'd0, halted}, 32'd0);
        check("resume_pc", 32'(rom_addr), 32'(model_pc));
        run_vec(16'hE090, 16'h0002, 16'h0003, 16'h0000, 16'h0005, 3'b010, (model_pc + 1) % 32768);

        // PC wrap from the top of ROM space.
        run_vec(16'hEA87, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 3'b000, 32'h7FFF);
        run_vec(16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0005, 3'b100, 0);

        // Reset during EXECUTE of a D write.
        env_a = 16'h0007;
        env_d = 16'h0005;
        rom[model_pc] = 16'hE090;
        cycle();
        check("pre_reset_d_en", {31'd0, reg_d_en}, 32'd1);
        rst = 1'b1;
        #1;
        check("reset_exec_d_en", {31'd0, reg_d_en}, 32'd0);
        check("reset_exec_data", 32'(data_out), 32'd0);
        cycle();
        check("reset_exec_d_kept", 32'(env_d), 32'h0005);
        check("reset_exec_pc", 32'(rom_addr), 32'd0);
        check("reset_exec_retired", retired, 32'd0);
        rst = 1'b0;
        model_pc = 0;
        model_ret = 0;
        run_vec(16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 3'b100, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/luna_cpu_control.md
Name: luna_cpu_control

Overview:
- Instruction-side initiator for the Luna A/D/M register-and-RAM block. It fetches 16-bit Hack-style instructions from a synchronous instruction ROM and decodes them.
- It computes the ALU result and drives the memory block's address, data and write-enables, then updates the PC (program counter).
- It sits between the instruction ROM and the memory block.
- Each instruction takes two cycles: FETCH, then EXECUTE.

Parameters:
- PC_W, 15, width of the PC and instruction ROM address.
- MADDR_W, 13, data memory address width; the low MADDR_W bits of A are used.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_addr  out  PC_W  instruction ROM address; always equals pc.
- rom_data  in  16  instruction word; valid one cycle after rom_addr.
- mem_addr  out  MADDR_W  data memory address; equals reg_a_in[MADDR_W-1:0].
- reg_a_in  in  16  current A register value.
- reg_d_in  in  16  current D register value.
- reg_m_in  in  16  current M value, i.e. mem[mem_addr], combinational.
- data_out  out  16  write data shared by A, D and M.
- reg_a_en  out  1  write-enable for A.
- reg_d_en  out  1  write-enable for D.
- reg_m_en  out  1  write-enable for M.
- halt_req  in  1  request to stop before the next instruction.
- halted  out  1  high while in the HALT state.
- retired  out  32  count of executed instructions; wraps modulo 2^32.

Behaviour:
- Reset, while rst=1 at an edge:
  - state=FETCH, pc=0, retired=0, halted=0.
  - reg_a_en, reg_d_en and reg_m_en are forced to 0 combinationally while rst=1.
  - data_out=0.
- Reset takes priority over all events. Reset during EXECUTE suppresses all writes and the PC update of that cycle.
- States:
  - FETCH: drive rom_addr=pc; all enables 0.
    - If halt_req=1, go to HALT.
    - Otherwise go to EXECUTE.
  - EXECUTE: rom_data holds the instruction. Enables are asserted for exactly this one cycle. At the edge: update pc, increment retired, go to FETCH. halt_req is ignored in this state.
  - HALT: halted=1, enables 0, pc held. Return to FETCH when halt_req=0.
- A-instruction (bit15=0), in EXECUTE:
  - data_out={1'b0, instr[14:0]}.
  - reg_a_en=1, reg_d_en=0, reg_m_en=0.
  - pc<=pc+1.
- C-instruction (bit15=1). Bits 14:13 are ignored.
  - Field layout: a=bit12; zx,nx,zy,ny,f,no = bits 11..6; dA,dD,dM = bits 5..3; jlt,jeq,jgt = bits 2..0.
  - ALU operands: x=reg_d_in; y = a ? reg_m_in : reg_a_in.
  - ALU pipeline:
    - x1 = zx?0:x, then x2 = nx?~x1:x1.
    - y1 = zy?0:y, then y2 = ny?~y1:y1.
    - r = f ? x2+y2 (mod 2^16) : x2&y2.
    - out = no?~r:r.
  - Flags: zr = (out==0); ng = out[15].
  - data_out=out; reg_a_en=dA; reg_d_en=dD; reg_m_en=dM.
  - Jump taken = (jlt&ng) | (jeq&zr) | (jgt&~ng&~zr).
  - If taken, pc <= reg_a_in[PC_W-1:0], the OLD A value sampled during EXECUTE. Otherwise pc<=pc+1.
- Simultaneous writes: with dA=1 and dM=1, M is written at the old mem_addr, because A and M update on the same edge. The jump target likewise uses the old A.
- PC wrap: pc+1 at 2^PC_W-1 wraps to 0.
- data_out is a don't-care outside EXECUTE, but it must stay driven (no X). It is the decoded value of rom_data.

Decomposition:
- Shared package luna_isa_pkg holds:
  - the state enum {FETCH, EXECUTE, HALT};
  - bit-position constants for a, the c-bits, the d-bits and the j-bits;
  - the constant INSTR_W=16.
- Sub-module luna_alu: purely combinational. Inputs x, y, the six control bits. Outputs out, zr, ng.

Test Plan:
- Reset and first fetch: rst high 3 cycles, then low → pc=0, enables 0, halted=0; rom_addr=0 in the first post-reset cycle.
- A-instruction: ROM[0]=0x1234 → in EXECUTE, data_out=0x1234 and reg_a_en=1 for exactly one cycle; pc=1 and retired=1 after it.
- C-instruction D=D+A: D=5, A=7, instr 0xE090 (a=0, c=000010, d=010) → data_out=12, only reg_d_en=1; pc increments.
- Jump on zero: D=0, A=0x0010, instr 0xE302 (D;JEQ) → no enables; pc=0x0010 after EXECUTE. Same instr with D=3 → pc+1.
- AM=M+1 with A=5, mem[5]=9: instr 0xFDE8 → data_out=10, reg_a_en=reg_m_en=1; mem[5]=10 and A=10 afterwards. Confirms the old-address write.
- Halt/reset mid-run:
  - halt_req=1 asserted during EXECUTE → that instruction completes, then HALT; pc is held while halt_req=1.
  - Release → FETCH at the same pc.
  - rst=1 during EXECUTE of a D-write → reg_d_en=0; pc=0 after the edge.
